// File: rtl/pwm_duty_ramp_pkg.sv
// pwm_duty_ramp_pkg
//   Types and constants shared by the duty-ramp sequencer, its period
//   counter and the downstream PWM generator.
//   - PWM_WIDTH  : default duty / period-counter width (period = 2^PWM_WIDTH)
//   - PWM_STEP_W : default width of the per-period step-size input
//   - ramp_state_t : sequencer FSM encoding
package pwm_duty_ramp_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    FINISH = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp_period_counter.sv
// pwm_period_counter
//   Free-running WIDTH-bit period counter. The PWM generator instantiates the
//   same module, so both counters restart together from reset and stay in phase.
//   Ports:
//     CLK        : clock, rising edge
//     RST        : synchronous active-high reset, clears the count
//     COUNT      : current position inside the PWM period
//     PERIOD_END : high while COUNT is at its last value (2^WIDTH-1)
module pwm_period_counter
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] COUNT,
  output logic             PERIOD_END
);

  logic [WIDTH-1:0] count_reg;

  // Natural wrap from all-ones back to zero closes each period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign COUNT      = count_reg;
  assign PERIOD_END = &count_reg;

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Soft-start duty sequencer feeding the PWM generator. A new target duty is
//   taken over a valid/ready handshake, then DUTY_OUT is slewed toward it by at
//   most one step per PWM period. Changes are applied only on the edge that
//   closes a period, so the generator never sees a duty change mid-period.
//   Ports:
//     CLK          : clock, rising edge
//     RST          : synchronous active-high reset; aborts any ramp
//     TARGET_IN    : requested duty
//     TARGET_VALID : TARGET_IN / STEP_IN are valid
//     TARGET_READY : sequencer idle and able to take a new target
//     STEP_IN      : max duty change per period (0 behaves as 1), sampled on handshake
//     DUTY_OUT     : current duty, drives the generator's PWM_IN
//     PERIOD_END   : high on the last cycle of each PWM period
//     BUSY         : ramp in progress
//     DONE         : one-cycle pulse once DUTY_OUT has reached the target
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int STEP_W = PWM_STEP_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  TARGET_IN,
  input  logic              TARGET_VALID,
  output logic              TARGET_READY,
  input  logic [STEP_W-1:0] STEP_IN,
  output logic [WIDTH-1:0]  DUTY_OUT,
  output logic              PERIOD_END,
  output logic              BUSY,
  output logic              DONE
);

  ramp_state_t       state_reg;
  logic [WIDTH-1:0]  duty_reg;
  logic [WIDTH-1:0]  target_reg;
  logic [STEP_W-1:0] step_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [WIDTH-1:0]  period_count;
  logic              period_end;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_period_counter (
    .CLK        (CLK),
    .RST        (RST),
    .COUNT      (period_count),
    .PERIOD_END (period_end)
  );

  // The count itself is only needed by the PWM generator's copy of the
  // counter; the sequencer works purely from the boundary decode.
  logic unused_period_count;
  assign unused_period_count = ^period_count;

  // Signed distance to the target at one extra bit, so the sign bit tells the
  // ramp direction and the magnitude can never alias.
  logic [WIDTH:0]    diff_signed;
  logic              ramp_down;
  logic [WIDTH:0]    diff_mag;
  logic [WIDTH:0]    step_ext;
  logic              last_step;
  logic [WIDTH-1:0]  duty_stepped;
  logic [STEP_W-1:0] step_eff;

  assign diff_signed  = {1'b0, target_reg} - {1'b0, duty_reg};
  assign ramp_down    = diff_signed[WIDTH];
  assign diff_mag     = ramp_down ? (~diff_signed + (WIDTH+1)'(1)) : diff_signed;
  assign step_ext     = (WIDTH+1)'(step_reg);
  // Landing exactly on the target whenever it is within one step is what
  // keeps DUTY_OUT from overshooting or wrapping past 0 / full scale.
  assign last_step    = (diff_mag <= step_ext);
  assign duty_stepped = ramp_down ? (duty_reg - WIDTH'(step_reg))
                                  : (duty_reg + WIDTH'(step_reg));

  assign step_eff     = (STEP_IN == '0) ? STEP_W'(1) : STEP_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      duty_reg   <= '0;
      target_reg <= '0;
      step_reg   <= STEP_W'(1);
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          // Ready is asserted whenever this branch runs, so VALID alone
          // completes the handshake here.
          if (TARGET_VALID) begin
            target_reg <= TARGET_IN;
            step_reg   <= step_eff;
            if (TARGET_IN == duty_reg) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= RAMP;
              busy_reg  <= 1'b1;
            end
          end
        end

        RAMP: begin
          // A handshake that lands on a period end enters RAMP one cycle
          // later, so that boundary is naturally skipped.
          if (period_end) begin
            if (last_step) begin
              duty_reg  <= target_reg;
              state_reg <= FINISH;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              duty_reg <= duty_stepped;
            end
          end
        end

        FINISH: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Ready is a decode of the state register, held low while reset is applied.
  assign TARGET_READY = (state_reg == IDLE) && !RST;
  assign DUTY_OUT     = duty_reg;
  assign PERIOD_END   = period_end;
  assign BUSY         = busy_reg;
  assign DONE         = done_reg;

endmodule
